// File: rtl/seq_digit_mac.sv
// -----------------------------------------------------------------------------
// seq_digit_mac
//   Sequential digit-serial unsigned multiplier with an optional running
//   accumulator. Each operand is split into K = N/D digits of D bits; one
//   DxD partial product is formed per cycle and shifted into a 2N-bit partial
//   sum, so a full multiply takes K*K CALC cycles.
//
//   Parameters
//     N : operand width (N >= D, N % D == 0)
//     D : digit width
//     G : accumulator guard bits
//
//   Ports
//     clk     : clock, rising edge
//     rst     : asynchronous active-high reset
//     start   : request a new multiply (accepted in IDLE or DONE)
//     a, b    : unsigned operands, captured at the accepted start
//     acc_en  : add the product into acc at completion (captured at start)
//     acc_clr : zero acc and ovf at the accepted start
//     busy    : high during CALC
//     done    : one-cycle completion pulse (the DONE state)
//     prod    : product of the last completed operation
//     acc     : running accumulator, 2N+G bits
//     ovf     : sticky accumulator carry-out
// -----------------------------------------------------------------------------
module seq_digit_mac #(
    parameter int N = 8,
    parameter int D = 2,
    parameter int G = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   prod,
    output logic [2*N+G-1:0] acc,
    output logic             ovf
);

    localparam int K  = N / D;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = 2 * N;
    localparam int AW = 2 * N + G;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            en_q;
    logic [IW-1:0]   i_idx;     // outer digit index (a)
    logic [IW-1:0]   j_idx;     // inner digit index (b)
    logic [PW-1:0]   psum;

    logic [D-1:0]    a_dig;
    logic [D-1:0]    b_dig;
    logic [2*D-1:0]  pp;
    logic [PW-1:0]   term;
    logic [PW-1:0]   psum_nxt;
    logic [AW:0]     acc_sum;   // one extra bit holds the carry-out
    logic            last;

    // Partial-product datapath. The largest shift is D*(2K-2) = 2N-2D, so a
    // 2D-bit partial product always fits in the 2N-bit sum without loss.
    always_comb begin
        a_dig    = D'(a_q >> (D * int'(i_idx)));
        b_dig    = D'(b_q >> (D * int'(j_idx)));
        pp       = a_dig * b_dig;
        term     = PW'(pp) << (D * (int'(i_idx) + int'(j_idx)));
        psum_nxt = psum + term;
        acc_sum  = {1'b0, acc} + (AW+1)'(psum_nxt);
        last     = (i_idx == IW'(K - 1)) && (j_idx == IW'(K - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            prod  <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            en_q  <= 1'b0;
            i_idx <= '0;
            j_idx <= '0;
            psum  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        a_q   <= a;
                        b_q   <= b;
                        en_q  <= acc_en;
                        i_idx <= '0;
                        j_idx <= '0;
                        psum  <= '0;
                        // Clear happens now, so the completion add sees zero.
                        if (acc_clr) begin
                            acc <= '0;
                            ovf <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                CALC: begin
                    // start is ignored here: operands and indices are frozen.
                    psum <= psum_nxt;
                    if (j_idx == IW'(K - 1)) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        prod  <= psum_nxt;
                        if (en_q) begin
                            acc <= acc_sum[AW-1:0];
                            ovf <= ovf | acc_sum[AW];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_digit_mac.sv
// -----------------------------------------------------------------------------
// tb_seq_digit_mac
//   Scoreboard bench for seq_digit_mac. Five instances cover the (N,D,G)
//   combinations of interest:
//     u0 (8,2,4)  u1 (8,4,4)  u2 (12,3,4)  u3 (4,1,4)  u4 (4,2,0)
//   Each start pushes an expected {prod, acc, ovf, done-cycle} entry; a
//   per-instance monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_seq_digit_mac;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [4:0] st  = '0;
    logic [4:0] en  = '0;
    logic [4:0] clr = '0;
    logic [4:0] bz, dn, ov;

    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [11:0] a2 = '0, b2 = '0;
    logic [3:0]  a3 = '0, b3 = '0, a4 = '0, b4 = '0;
    logic [15:0] prod0, prod1;
    logic [23:0] prod2;
    logic [7:0]  prod3, prod4;
    logic [19:0] acc0, acc1;
    logic [27:0] acc2;
    logic [11:0] acc3;
    logic [7:0]  acc4;

    seq_digit_mac #(.N(8), .D(2), .G(4)) u0 (.clk(clk), .rst(rst), .start(st[0]), .a(a0), .b(b0),
        .acc_en(en[0]), .acc_clr(clr[0]), .busy(bz[0]), .done(dn[0]), .prod(prod0), .acc(acc0), .ovf(ov[0]));
    seq_digit_mac #(.N(8), .D(4), .G(4)) u1 (.clk(clk), .rst(rst), .start(st[1]), .a(a1), .b(b1),
        .acc_en(en[1]), .acc_clr(clr[1]), .busy(bz[1]), .done(dn[1]), .prod(prod1), .acc(acc1), .ovf(ov[1]));
    seq_digit_mac #(.N(12), .D(3), .G(4)) u2 (.clk(clk), .rst(rst), .start(st[2]), .a(a2), .b(b2),
        .acc_en(en[2]), .acc_clr(clr[2]), .busy(bz[2]), .done(dn[2]), .prod(prod2), .acc(acc2), .ovf(ov[2]));
    seq_digit_mac #(.N(4), .D(1), .G(4)) u3 (.clk(clk), .rst(rst), .start(st[3]), .a(a3), .b(b3),
        .acc_en(en[3]), .acc_clr(clr[3]), .busy(bz[3]), .done(dn[3]), .prod(prod3), .acc(acc3), .ovf(ov[3]));
    seq_digit_mac #(.N(4), .D(2), .G(0)) u4 (.clk(clk), .rst(rst), .start(st[4]), .a(a4), .b(b4),
        .acc_en(en[4]), .acc_clr(clr[4]), .busy(bz[4]), .done(dn[4]), .prod(prod4), .acc(acc4), .ovf(ov[4]));

    // K*K, accumulator width 2N+G, operand mask per instance
    int          KK  [5] = '{16, 4, 16, 16, 4};
    int          AW  [5] = '{20, 20, 28, 12, 8};
    logic [63:0] MSK [5] = '{64'd255, 64'd255, 64'd4095, 64'd15, 64'd15};

    typedef struct {
        logic [63:0] prod;
        logic [63:0] acc;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        q [5][$];
    logic [63:0] acc_m [5] = '{default: 64'd0};
    logic        ovf_m [5] = '{default: 1'b0};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // Reference model: acc and ovf behaviour computed from plain integer math.
    function automatic void push(input int k, input logic [63:0] av, input logic [63:0] bv,
                                 input bit e, input bit c);
        exp_t        x;
        logic [63:0] s;
        if (c) begin
            acc_m[k] = 64'd0;
            ovf_m[k] = 1'b0;
        end
        x.prod = av * bv;
        if (e) begin
            s = acc_m[k] + x.prod;
            if ((s >> AW[k]) != 64'd0) ovf_m[k] = 1'b1;
            acc_m[k] = s & ((64'd1 << AW[k]) - 64'd1);
        end
        x.acc = acc_m[k];
        x.ovf = ovf_m[k];
        x.cyc = cyc + 1 + KK[k];
        q[k].push_back(x);
    endfunction

    // Called at a negedge; start stays high until the caller drops it.
    task automatic drive(input int k, input logic [63:0] av, input logic [63:0] bv,
                         input bit e, input bit c);
        st[k] = 1'b1; en[k] = e; clr[k] = c;
        case (k)
            0: begin a0 = av[7:0];  b0 = bv[7:0];  end
            1: begin a1 = av[7:0];  b1 = bv[7:0];  end
            2: begin a2 = av[11:0]; b2 = bv[11:0]; end
            3: begin a3 = av[3:0];  b3 = bv[3:0];  end
            default: begin a4 = av[3:0]; b4 = bv[3:0]; end
        endcase
        push(k, av, bv, e, c);
    endtask

    // One isolated operation: pulse start, wait for the scoreboard to drain,
    // count busy cycles along the way.
    task automatic op(input int k, input logic [63:0] av, input logic [63:0] bv,
                      input bit e, input bit c);
        int nb = 0;
        int w  = 0;
        drive(k, av, bv, e, c);
        @(negedge clk);
        st[k] = 1'b0;
        if (bz[k]) nb++;
        while (q[k].size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
            if (bz[k]) nb++;
        end
        if (w >= 200) begin
            chk($sformatf("u%0d_timeout", k), 64'(w), 64'd0);
            q[k].delete();
        end
        chk($sformatf("u%0d_busy_cycles", k), 64'(nb), 64'(KK[k]));
    endtask

    task automatic mon(input int k, input logic d, input logic [63:0] p,
                       input logic [63:0] ac, input logic o);
        exp_t x;
        if (d) begin
            if (q[k].size() == 0) begin
                chk($sformatf("u%0d_unexpected_done", k), 64'd1, 64'd0);
            end else begin
                x = q[k].pop_front();
                chk($sformatf("u%0d_prod", k), p, x.prod);
                chk($sformatf("u%0d_acc", k), ac, x.acc);
                chk($sformatf("u%0d_ovf", k), 64'(o), 64'(x.ovf));
                chk($sformatf("u%0d_done_cycle", k), 64'(cyc), 64'(x.cyc));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, dn[0], 64'(prod0), 64'(acc0), ov[0]);
        mon(1, dn[1], 64'(prod1), 64'(acc1), ov[1]);
        mon(2, dn[2], 64'(prod2), 64'(acc2), ov[2]);
        mon(3, dn[3], 64'(prod3), 64'(acc3), ov[3]);
        mon(4, dn[4], 64'(prod4), 64'(acc4), ov[4]);
    end

    task automatic rnd(input int k, input int n_ops);
        for (int n = 0; n < n_ops; n++) begin
            op(k, 64'($urandom) & MSK[k], 64'($urandom) & MSK[k],
               bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=%0d exp=0", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int nd;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(bz[0]), 64'd0);
        chk("rst_done", 64'(dn[0]), 64'd0);
        chk("rst_prod", 64'(prod0), 64'd0);
        chk("rst_acc",  64'(acc0), 64'd0);
        chk("rst_ovf",  64'(ov[0]), 64'd0);

        // Basic products, acc_en = 0 leaves acc alone
        op(0, 64'd200, 64'd100, 1'b0, 1'b0);
        chk("p_200x100", 64'(prod0), 64'd20000);
        op(0, 64'd255, 64'd255, 1'b0, 1'b0);
        chk("p_255x255", 64'(prod0), 64'd65025);
        op(0, 64'd0, 64'd173, 1'b0, 1'b0);
        chk("p_0x173", 64'(prod0), 64'd0);

        // Accumulation
        op(0, 64'd12, 64'd13, 1'b1, 1'b1);
        chk("acc_156", 64'(acc0), 64'd156);
        op(0, 64'd7, 64'd9, 1'b1, 1'b0);
        chk("acc_219", 64'(acc0), 64'd219);
        op(0, 64'd3, 64'd5, 1'b1, 1'b0);
        chk("acc_234", 64'(acc0), 64'd234);
        chk("acc_ovf0", 64'(ov[0]), 64'd0);

        // G = 0 overflow and clear
        op(4, 64'd15, 64'd15, 1'b1, 1'b1);
        chk("g0_acc_225", 64'(acc4), 64'd225);
        op(4, 64'd15, 64'd15, 1'b1, 1'b0);
        chk("g0_acc_194", 64'(acc4), 64'd194);
        chk("g0_ovf_set", 64'(ov[4]), 64'd1);
        op(4, 64'd1, 64'd1, 1'b1, 1'b1);
        chk("g0_acc_1", 64'(acc4), 64'd1);
        chk("g0_ovf_clr", 64'(ov[4]), 64'd0);

        // Back-to-back: start held high throughout, operands scrambled mid-op
        @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            drive(0, 64'($urandom) & 64'd255, 64'($urandom) & 64'd255, 1'b0, 1'b0);
            repeat (8) @(negedge clk);
            a0 = 8'($urandom);
            b0 = 8'($urandom);
            w = 0;
            while (!dn[0] && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) chk("b2b_timeout", 64'(w), 64'd0);
        end
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_drained", 64'(q[0].size()), 64'd0);

        // Reset in CALC cycle 7
        drive(0, 64'd200, 64'd55, 1'b1, 1'b0);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(bz[0]), 64'd0);
        chk("mid_rst_done", 64'(dn[0]), 64'd0);
        chk("mid_rst_prod", 64'(prod0), 64'd0);
        chk("mid_rst_acc",  64'(acc0), 64'd0);
        chk("mid_rst_ovf",  64'(ov[0]), 64'd0);
        for (int k = 0; k < 5; k++) begin
            q[k].delete();
            acc_m[k] = 64'd0;
            ovf_m[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (dn[0]) nd++;
        end
        chk("mid_rst_no_done", 64'(nd), 64'd0);
        op(0, 64'd9, 64'd9, 1'b0, 1'b0);
        chk("p_9x9", 64'(prod0), 64'd81);

        // Randomized, all widths concurrently
        fork
            rnd(0, 1000);
            rnd(1, 1000);
            rnd(2, 1000);
            rnd(3, 1000);
        join

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
